sram_loader: RTL and testbench
==============================

# sram_loader

Upstream feeder for the TPU core. Accepts a byte stream over a valid/ready handshake, packs bytes into SRAM words, and writes them into the two weight banks (w0/w1) and then the two data banks (d0/d1). After the last data word is written it pulses `tpu_start` and holds busy until the core reports `tpu_done`. It sits between the host/testbench stream source and the weight/data SRAMs that the core reads.

## Interface
Parameters:
- `SRAM_DATA_WIDTH`, default 32: SRAM word width.
- `DATA_WIDTH`, default 8: stream element width. `SRAM_DATA_WIDTH/DATA_WIDTH` (BPW, 4) must be an integer ≥2.
- `W_WORDS`, default 16: words written per weight bank. Range 1..1024.
- `D_WORDS`, default 16: words written per data bank. Range 1..1024.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low, named `clk` and `srstn` as in the rest of the design.
- `clk`, input, 1: clock; all logic is on the rising edge.
- `srstn`, input, 1: synchronous active-low reset.
- `load_go`, input, 1: starts a load; sampled only in IDLE.
- `in_valid`, input, 1: stream element valid.
- `in_ready`, output, 1: loader can accept an element.
- `in_data`, input, DATA_WIDTH: stream element.
- `sram_write_enable_w0`, `_w1`, `_d0`, `_d1`, output, 1 each: active-high write strobes.
- `sram_waddr`, output, 10: bank-local word address, shared by all four banks.
- `sram_wdata`, output, SRAM_DATA_WIDTH: packed word, shared by all four banks.
- `tpu_start`, output, 1: one-cycle start pulse to the core.
- `tpu_done`, input, 1: completion from the core.
- `busy`, output, 1: high in every state except IDLE.
- `checksum`, output, 16: running byte sum (see Configuration).

## Operation
- States: IDLE, LOAD_W, LOAD_D, START, RUN.
- IDLE: `in_ready`=0. When `load_go`=1, go to LOAD_W and clear the byte counter, word counter and checksum.
- LOAD_W / LOAD_D: `in_ready`=1. A byte is accepted on each cycle with `in_valid && in_ready`.
- Byte packing is MSB-first: the first byte of a word goes to bits [SRAM_DATA_WIDTH-1 : SRAM_DATA_WIDTH-DATA_WIDTH] and the BPW-th byte goes to [DATA_WIDTH-1:0].
- Word order within a phase alternates banks, with a global word index g starting at 0:
  - even g goes to bank 0 (w0/d0), odd g goes to bank 1 (w1/d1);
  - `sram_waddr` = g>>1.
- LOAD_W writes 2·W_WORDS words. When the last weight byte is accepted, the state moves to LOAD_D and g resets to 0.
- LOAD_D writes 2·D_WORDS words. When the last data byte is accepted, the state moves to START.
- START: `tpu_start`=1 for exactly one cycle, then RUN.
- RUN: wait for `tpu_done`=1, then IDLE.
- `tpu_done` is ignored in every state except RUN. `load_go` is ignored in every state except IDLE.
- Word counter width is 11 bits, so 2·1024 words must not overflow it.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, pack register 0.
- Write latency: a write strobe, with `sram_waddr` and `sram_wdata`, is high for exactly one cycle. That cycle is the one after the cycle that accepts the word's final byte. At most one strobe is high in any cycle.
- `in_ready` is never deasserted for write back-pressure. Full stream rate is one byte per cycle.
- The final data word's strobe and the START state occur in the same cycle, so `tpu_start` is high in that cycle. `tpu_start` is 1 on cycle N+1, where N is the cycle that accepts the final byte.
- Bubbles (`in_valid`=0) only stall packing. A partial word is held indefinitely.
- `busy` drops the cycle after `tpu_done` is sampled in RUN. A new `load_go` is accepted on the following cycle or later.
- If reset is asserted mid-load, a partially packed word is discarded and no strobe fires. Words already written are not retracted.

## Configuration
- `SRAM_LOADER_CHECKSUM_EN` defined:
  - `checksum` is a 16-bit sum of every accepted byte, treated as unsigned and wrapping modulo 2^16;
  - it is cleared when `load_go` is accepted and holds its value through START, RUN and IDLE.
- Not defined: `checksum` is tied to 0 and no adder is instantiated.

## Test plan
- Minimal load, W_WORDS=D_WORDS=1, stream bytes 0x01..0x10 back-to-back:
  - w0@0=0x01020304, w1@0=0x05060708, d0@0=0x090A0B0C, d1@0=0x0D0E0F10;
  - `tpu_start` pulses one cycle after byte 0x10 is accepted;
  - checksum = 0x0088.
- Default sizes with random `in_valid` gaps: 256 bytes produce 64 strobes, each exactly one cycle with correct bank alternation. Addresses run 0..15 per bank and no strobe fires during gaps.
- RUN with `tpu_done` held 0 for 100 cycles, then a one-cycle pulse: `busy` stays 1 until the cycle after the pulse. A `load_go` during RUN is ignored.
- Reset after 6 bytes of the minimal load: only the w0@0 strobe was seen, all outputs read 0 next cycle, and a fresh load then completes correctly.
- `tpu_done` pulse during IDLE or LOAD_W: no state change and no `tpu_start`.
- Checksum wrap with the macro on, 512 bytes of 0xFF: checksum = 0xFE00. With the macro off: checksum = 0.

Source files
------------

// File: rtl/sram_loader.sv
// sram_loader: packs an MSB-first byte stream into words for banks w0/w1 then d0/d1, then pulses tpu_start and waits for tpu_done.
// Strobes fire one cycle after a word's last byte; in_ready never drops for writes. SRAM_LOADER_CHECKSUM_EN enables the byte checksum.
module sram_loader #(
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int DATA_WIDTH      = 8,
  parameter int W_WORDS         = 16,
  parameter int D_WORDS         = 16
) (
  input  logic                       clk,
  input  logic                       srstn,
  input  logic                       load_go,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       sram_write_enable_w0,
  output logic                       sram_write_enable_w1,
  output logic                       sram_write_enable_d0,
  output logic                       sram_write_enable_d1,
  output logic [9:0]                 sram_waddr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
  output logic                       tpu_start,
  input  logic                       tpu_done,
  output logic                       busy,
  output logic [15:0]                checksum
);

  localparam int BPW = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int BCW = $clog2(BPW);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [10:0]    W_LAST    = 11'(2 * W_WORDS - 1);
  localparam logic [10:0]    D_LAST    = 11'(2 * D_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, START, RUN} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [BCW-1:0]             r_byte_cnt;
  logic [10:0]                r_word_cnt;
  logic [SRAM_DATA_WIDTH-1:0] r_pack;
  logic [3:0]                 r_we;
  logic [9:0]                 r_waddr;
  logic [SRAM_DATA_WIDTH-1:0] r_wdata;

  logic                       w_loading;
  logic                       w_accept;
  logic                       w_word_done;
  logic                       w_phase_done;
  logic                       w_start_load;
  logic [SRAM_DATA_WIDTH-1:0] w_word;

  assign w_loading    = (r_state == LOAD_W) || (r_state == LOAD_D);
  assign in_ready     = w_loading;
  assign w_accept     = in_valid && w_loading;
  assign w_word       = {r_pack[SRAM_DATA_WIDTH-DATA_WIDTH-1:0], in_data};
  assign w_word_done  = w_accept && (r_byte_cnt == LAST_BYTE);
  assign w_phase_done = w_word_done &&
                        (r_word_cnt == ((r_state == LOAD_W) ? W_LAST : D_LAST));

  always_ff @(posedge clk) begin
    if (!srstn) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    busy         = 1'b1;
    tpu_start    = 1'b0;
    w_start_load = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (load_go) begin
          w_next       = LOAD_W;
          w_start_load = 1'b1;
        end
      end
      LOAD_W:  if (w_phase_done) w_next = LOAD_D;
      LOAD_D:  if (w_phase_done) w_next = START;
      START: begin
        tpu_start = 1'b1;
        w_next    = RUN;
      end
      RUN:     if (tpu_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Write strobe and its address/data are registered so they appear the cycle after the final byte.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_pack     <= '0;
      r_we       <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= '0;
      if (w_start_load) begin
        r_byte_cnt <= '0;
        r_word_cnt <= '0;
        r_pack     <= '0;
      end else if (w_accept) begin
        r_pack <= w_word;
        if (w_word_done) begin
          r_byte_cnt <= '0;
          r_waddr    <= r_word_cnt[10:1];
          r_wdata    <= w_word;
          if (r_state == LOAD_W) r_we <= r_word_cnt[0] ? 4'b0100 : 4'b1000;
          else                   r_we <= r_word_cnt[0] ? 4'b0001 : 4'b0010;
          r_word_cnt <= w_phase_done ? 11'd0 : r_word_cnt + 11'd1;
        end else begin
          r_byte_cnt <= r_byte_cnt + BCW'(1);
        end
      end
    end
  end

  assign sram_write_enable_w0 = r_we[3];
  assign sram_write_enable_w1 = r_we[2];
  assign sram_write_enable_d0 = r_we[1];
  assign sram_write_enable_d1 = r_we[0];
  assign sram_waddr           = r_waddr;
  assign sram_wdata           = r_wdata;

`ifdef SRAM_LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk) begin
    if (!srstn)            r_checksum <= '0;
    else if (w_start_load) r_checksum <= '0;
    else if (w_accept)     r_checksum <= r_checksum + 16'(in_data);
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_sram_loader.sv
// Directed bench for sram_loader: three instances (1/1, 16/16, 32/32 words per bank) sharing stream inputs.
module tb_sram_loader;

`ifdef SRAM_LOADER_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srstn, in_valid, tpu_done;
  logic [7:0] in_data;
  logic [2:0] go;

  logic        m_rdy, m_w0, m_w1, m_d0, m_d1, m_start, m_busy;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [15:0] m_cks;
  logic        d_rdy, d_w0, d_w1, d_d0, d_d1, d_start, d_busy;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic [15:0] d_cks;
  logic        b_rdy, b_w0, b_w1, b_d0, b_d1, b_start, b_busy;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata;
  logic [15:0] b_cks;

  sram_loader #(.SRAM_DATA_WIDTH(32), .DATA_WIDTH(8), .W_WORDS(1), .D_WORDS(1)) u_min (
    .clk(clk), .srstn(srstn), .load_go(go[0]), .in_valid(in_valid), .in_ready(m_rdy),
    .in_data(in_data), .sram_write_enable_w0(m_w0), .sram_write_enable_w1(m_w1),
    .sram_write_enable_d0(m_d0), .sram_write_enable_d1(m_d1), .sram_waddr(m_addr),
    .sram_wdata(m_wdata), .tpu_start(m_start), .tpu_done(tpu_done), .busy(m_busy),
    .checksum(m_cks));

  sram_loader #(.SRAM_DATA_WIDTH(32), .DATA_WIDTH(8), .W_WORDS(16), .D_WORDS(16)) u_def (
    .clk(clk), .srstn(srstn), .load_go(go[1]), .in_valid(in_valid), .in_ready(d_rdy),
    .in_data(in_data), .sram_write_enable_w0(d_w0), .sram_write_enable_w1(d_w1),
    .sram_write_enable_d0(d_d0), .sram_write_enable_d1(d_d1), .sram_waddr(d_addr),
    .sram_wdata(d_wdata), .tpu_start(d_start), .tpu_done(tpu_done), .busy(d_busy),
    .checksum(d_cks));

  sram_loader #(.SRAM_DATA_WIDTH(32), .DATA_WIDTH(8), .W_WORDS(32), .D_WORDS(32)) u_big (
    .clk(clk), .srstn(srstn), .load_go(go[2]), .in_valid(in_valid), .in_ready(b_rdy),
    .in_data(in_data), .sram_write_enable_w0(b_w0), .sram_write_enable_w1(b_w1),
    .sram_write_enable_d0(b_d0), .sram_write_enable_d1(b_d1), .sram_waddr(b_addr),
    .sram_wdata(b_wdata), .tpu_start(b_start), .tpu_done(tpu_done), .busy(b_busy),
    .checksum(b_cks));

  int          sel;
  logic [3:0]  o_we;
  logic [9:0]  o_addr;
  logic [31:0] o_wdata;
  logic        o_start, o_busy, o_rdy;
  logic [15:0] o_cks;

  always_comb begin
    o_we = {m_w0, m_w1, m_d0, m_d1};
    o_addr = m_addr; o_wdata = m_wdata; o_start = m_start;
    o_busy = m_busy; o_rdy = m_rdy; o_cks = m_cks;
    if (sel == 1) begin
      o_we = {d_w0, d_w1, d_d0, d_d1};
      o_addr = d_addr; o_wdata = d_wdata; o_start = d_start;
      o_busy = d_busy; o_rdy = d_rdy; o_cks = d_cks;
    end else if (sel == 2) begin
      o_we = {b_w0, b_w1, b_d0, b_d1};
      o_addr = b_addr; o_wdata = b_wdata; o_start = b_start;
      o_busy = b_busy; o_rdy = b_rdy; o_cks = b_cks;
    end
  end

  int          n_chk;
  int          n_pass;
  logic [31:0] cap [4];
  int          nstrobe;
  logic [45:0] rst_obs;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int bank_idx(input logic [3:0] we);
    case (we)
      4'b1000: return 0;
      4'b0100: return 1;
      4'b0010: return 2;
      default: return 3;
    endcase
  endfunction

  // mode 0: bytes 1,2,3..; mode 1: random bytes; mode 2: all 0xFF
  task automatic run_load(input int s, input int nw, input int nd, input int mode, input bit gaps);
    int          total, i, k, g, ns;
    logic [31:0] word;
    logic [45:0] pend, obs;
    logic [7:0]  b;
    logic [15:0] sum;
    total = (2 * nw + 2 * nd) * 4;
    for (int q = 0; q < 4; q++) cap[q] = 32'h0;
    sel = s;
    go[s] = 1'b1;
    step();
    go[s] = 1'b0;
    chk("load_entry", {o_busy, o_rdy, o_start, o_cks}, {3'b110, 16'h0});
    i = 0; word = 32'h0; pend = '0; ns = 0; sum = 16'h0;
    for (int cyc = 0; cyc < 4 * total + 100 && i < total; cyc++) begin
      obs = {o_we, o_addr, o_wdata};
      if (o_we != 4'h0) begin
        ns++;
        cap[bank_idx(o_we)] = o_wdata;
      end
      chk("strobe", (pend == '0) ? {o_we, 42'h0} : obs, pend);
      pend = '0;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      b = (mode == 0) ? 8'(i + 1) : (mode == 1) ? 8'($urandom) : 8'hFF;
      in_data = b;
      if (in_valid) begin
        word = {word[23:0], b};
        sum = sum + 16'(b);
        i++;
        if (i % 4 == 0) begin
          k = i / 4 - 1;
          if (k < 2 * nw) begin
            g = k;
            pend[45:42] = g[0] ? 4'b0100 : 4'b1000;
          end else begin
            g = k - 2 * nw;
            pend[45:42] = g[0] ? 4'b0001 : 4'b0010;
          end
          pend[41:32] = 10'(g >> 1);
          pend[31:0]  = word;
        end
      end
      step();
    end
    in_valid = 1'b0;
    chk("all_bytes_sent", i, total);
    obs = {o_we, o_addr, o_wdata};
    if (o_we != 4'h0) begin
      ns++;
      cap[bank_idx(o_we)] = o_wdata;
    end
    chk("last_strobe", obs, pend);
    chk("start_pulse", {o_start, o_busy, o_rdy}, 3'b110);
    chk("checksum", o_cks, CKS_EN ? sum : 16'h0);
    step();
    chk("run_entry", {o_start, o_busy, o_rdy, o_we}, {3'b010, 4'h0});
    chk("strobe_count", ns, total / 4);
  endtask

  task automatic finish_run();
    tpu_done = 1'b1;
    chk("busy_before_done", o_busy, 1'b1);
    step();
    tpu_done = 1'b0;
    chk("busy_drop", {o_busy, o_start, o_rdy}, 3'b000);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; sel = 0;
    srstn = 1'b0; in_valid = 1'b0; in_data = 8'h0; tpu_done = 1'b0; go = 3'b000;
    repeat (2) step();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_ctl", {o_we, o_start, o_busy, o_rdy, o_cks}, 23'h0);
      chk("reset_bus", {o_addr, o_wdata}, 42'h0);
    end
    srstn = 1'b1;
    step();

    // tpu_done in IDLE must not start anything
    sel = 0;
    tpu_done = 1'b1;
    step();
    tpu_done = 1'b0;
    chk("idle_done_ignored", {o_busy, o_start, o_rdy}, 3'b000);
    step();
    chk("idle_done_no_start", {o_busy, o_start}, 2'b00);

    run_load(0, 1, 1, 0, 1'b0);
    chk("min_w0", cap[0], 32'h01020304);
    chk("min_w1", cap[1], 32'h05060708);
    chk("min_d0", cap[2], 32'h090A0B0C);
    chk("min_d1", cap[3], 32'h0D0E0F10);
    chk("min_cks", o_cks, CKS_EN ? 16'h0088 : 16'h0000);

    repeat (100) step();
    chk("run_hold", {o_busy, o_rdy, o_start}, 3'b100);
    go[0] = 1'b1;
    step();
    go[0] = 1'b0;
    step();
    chk("run_go_ignored", {o_busy, o_rdy, o_start, o_we}, {3'b100, 4'h0});
    finish_run();

    // Reset after six bytes, with a tpu_done pulse while in LOAD_W
    go[0] = 1'b1;
    step();
    go[0] = 1'b0;
    nstrobe = 0;
    rst_obs = '0;
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1;
      in_data  = 8'(j + 1);
      tpu_done = (j == 1);
      step();
      if (o_we != 4'h0) begin
        nstrobe++;
        rst_obs = {o_we, o_addr, o_wdata};
      end
      if (j == 1) chk("loadw_done_ignored", {o_busy, o_rdy, o_start}, 3'b110);
    end
    in_valid = 1'b0;
    tpu_done = 1'b0;
    chk("partial_cks", o_cks, CKS_EN ? 16'h0015 : 16'h0000);
    srstn = 1'b0;
    step();
    chk("rst_strobes", nstrobe, 1);
    chk("rst_w0", rst_obs, {4'b1000, 10'd0, 32'h01020304});
    chk("midrst_ctl", {o_we, o_start, o_busy, o_rdy, o_cks}, 23'h0);
    chk("midrst_bus", {o_addr, o_wdata}, 42'h0);
    srstn = 1'b1;
    step();

    run_load(0, 1, 1, 0, 1'b0);
    chk("again_w0", cap[0], 32'h01020304);
    chk("again_w1", cap[1], 32'h05060708);
    chk("again_d0", cap[2], 32'h090A0B0C);
    chk("again_d1", cap[3], 32'h0D0E0F10);
    finish_run();

    run_load(1, 16, 16, 1, 1'b1);
    finish_run();

    run_load(2, 32, 32, 2, 1'b0);
    chk("wrap_cks", o_cks, CKS_EN ? 16'hFE00 : 16'h0000);
    finish_run();
    step();
    chk("cks_hold_idle", o_cks, CKS_EN ? 16'hFE00 : 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
